// File: rtl/imm_enc_pkg.sv
// Shared types and helpers for the immediate instruction encoder.
package imm_enc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM12_W = 12;

    // opcode[6:5] format codes; bit 6 alone selects SB
    localparam logic [1:0] OPC_FMT_I  = 2'b00;
    localparam logic [1:0] OPC_FMT_S  = 2'b01;
    localparam logic [1:0] OPC_FMT_SB = 2'b10;

    typedef enum logic [1:0] {
        FMT_I  = 2'd0,
        FMT_S  = 2'd1,
        FMT_SB = 2'd2
    } fmt_e;

    // Stage A payload
    typedef struct packed {
        fmt_e               fmt;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [IMM12_W-1:0] imm;
        logic               range_err;
    } enc_req_t;

    function automatic fmt_e fmt_of(input logic [6:0] opcode);
        fmt_e f;
        case (opcode[6:5])
            OPC_FMT_I: f = FMT_I;
            OPC_FMT_S: f = FMT_S;
            default:   f = FMT_SB;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational packer: format + fields + 12-bit immediate -> instruction word.
module imm_field_pack
    import imm_enc_pkg::*;
(
    input  fmt_e                 fmt,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [IMM12_W-1:0]   imm,
    output logic [INSTR_W-1:0]   word
);

    // Field placement per format; SB imm is already in halfword units
    always_comb begin
        word = '0;
        case (fmt)
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_SB:  word = {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Two-stage valid/ready encoder: 64-bit immediate + fields -> I/S/SB word.
module imm_instr_encoder
    import imm_enc_pkg::*;
#(
    parameter int unsigned IMM_W = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         in_opcode,
    input  logic [2:0]         in_funct3,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [IMM_W-1:0]   in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_range_err,
    output logic [CNT_W-1:0]   enc_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned  HI_W    = IMM_W - 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                a_valid;
    enc_req_t            a_q;
    enc_req_t            req;
    logic                adv_a;
    logic                adv_b;
    logic                out_fire;
    logic [HI_W-1:0]     imm_hi;
    logic [INSTR_W-1:0]  pack_word;

    assign adv_b    = !out_valid || out_ready;
    assign adv_a    = !a_valid || adv_b;
    assign in_ready = adv_a && !reset;
    assign out_fire = out_valid && out_ready;

    // Fits in signed 12 bits when bits [IMM_W-1:11] are all copies of the sign
    assign imm_hi = in_imm[IMM_W-1:11];

    always_comb begin
        req           = '0;
        req.fmt       = fmt_of(in_opcode);
        req.opcode    = in_opcode;
        req.funct3    = in_funct3;
        req.rd        = in_rd;
        req.rs1       = in_rs1;
        req.rs2       = in_rs2;
        req.imm       = in_imm[IMM12_W-1:0];
        req.range_err = !((&imm_hi) || (~|imm_hi));
    end

    // Stage A: capture request fields, format and range flag
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_q     <= '0;
        end else if (adv_a) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_q <= req;
            end
        end
    end

    imm_field_pack u_pack (
        .fmt    (a_q.fmt),
        .opcode (a_q.opcode),
        .funct3 (a_q.funct3),
        .rd     (a_q.rd),
        .rs1    (a_q.rs1),
        .rs2    (a_q.rs2),
        .imm    (a_q.imm),
        .word   (pack_word)
    );

    // Stage B: output register, holds while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_instr     <= '0;
            out_range_err <= 1'b0;
        end else if (adv_b) begin
            out_valid <= a_valid;
            if (a_valid) begin
                out_instr     <= pack_word;
                out_range_err <= a_q.range_err;
            end
        end
    end

    // Saturating handshake statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (out_fire) begin
            if (enc_count != CNT_MAX) begin
                enc_count <= enc_count + CNT_W'(1);
            end
            if (out_range_err && (err_count != CNT_MAX)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule
